mac_array_scheduler: RTL and testbench
======================================

# mac_array_scheduler

Sequencing controller for the MAC-array datapath. It buffers one A matrix (array_height_p × depth_p) and one B matrix (depth_p × array_width_p) from a single ready/valid input stream. It injects them into the array's row and column ports with systolic skew, waits for the products to settle, then streams the array_height_p × array_width_p results out over a valid/yumi producer port. It sits between the top-level stream interface and the mac_array instance, and replaces ad-hoc one-hot input steering.

## Interface
- width_p, 32, data word width
- array_width_p, 2, array columns (B columns)
- array_height_p, 2, array rows (A rows)
- depth_p, 2, inner dimension K (operands per row/column)
- settle_p, 4, cycles to wait after the last feed step before draining (≥1)
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- en_i  in  1  global enable; low freezes all state
- flush_i  in  1  abort current job
- valid_i / ready_o / data_i  in / out / width_p  operand input stream
- row_o  out  width_p*array_height_p  row operands, row r at [r*width_p +: width_p]
- row_valid_o / row_ready_i  out / in  array_height_p each  per-row handshake
- col_o  out  width_p*array_width_p  column operands, same packing
- col_valid_o / col_ready_i  out / in  array_width_p each  per-column handshake
- z_i  in  width_p*array_height_p*array_width_p  array results, index i = r*array_width_p + c
- valid_o / yumi_i / data_o  out / in / width_p  result stream
- array_reset_o  out  1  one-cycle clear pulse to mac_array
- busy_o  out  1  high in FEED, WAIT and DRAIN
- perf_cycles_o  out  32  job cycle count (see Configuration)

## Operation
- States (one-hot): IDLE, LOAD, FEED, WAIT, DRAIN, CLEAR.
- Load order: A row-major (A[0][0..depth_p-1], A[1][...], …), then B column-major (B[0..depth_p-1][0], B[...][1], …). Total L = (array_height_p + array_width_p)·depth_p words.
- IDLE: ready_o=1. An accepted word is written at index 0 and the state goes to LOAD.
- LOAD: ready_o=1. Each accepted word is written at the next index. Acceptance of word L-1 moves the state to FEED with step t=0.
- FEED: row r has row_valid_o[r]=1 iff r ≤ t < r+depth_p, with row_o[r]=A[r][t-r]. Column c has col_valid_o[c]=1 iff c ≤ t < c+depth_p, with col_o[c]=B[t-c][c]. Inactive lanes drive 0.
- Step t advances only in a cycle where every asserted valid sees its ready high. Otherwise all lanes hold their valid and data unchanged.
- FEED runs T = depth_p + max(array_height_p, array_width_p) - 1 steps. The advance out of step T-1 moves the state to WAIT.
- WAIT: counts settle_p cycles, then moves to DRAIN with index i=0.
- DRAIN: valid_o=1 and data_o = z_i[i*width_p +: width_p]. yumi_i increments i. yumi_i at the last index moves the state to CLEAR.
- CLEAR: array_reset_o=1 for exactly one cycle, then IDLE.
- flush_i in any state except CLEAR moves the state to CLEAR and zeroes all counters. flush_i has priority over valid_i and yumi_i in the same cycle; the colliding word or result is not consumed.
- en_i=0: ready_o, row_valid_o, col_valid_o, valid_o and array_reset_o are forced to 0. No state, counter or buffer changes occur.
- Products are not width-checked; the array owns the arithmetic.

## Timing
- Reset values: state IDLE, all counters 0, buffers 0, valid_o/row_valid_o/col_valid_o/array_reset_o/busy_o 0, perf_cycles_o 0. ready_o=en_i after reset deasserts.
- All outputs are driven from registered state; there are no combinational paths from ready/yumi to valid.
- Minimum job latency, with all readies high and yumi_i always high: L load cycles + T + settle_p + (array_height_p·array_width_p) + 1.
- Reset mid-job returns to IDLE immediately with no CLEAR pulse; the array sees reset_i directly.

## Configuration
- MAC_SCHED_PERF_EN defined: perf_cycles_o clears on the first accepted word in IDLE and increments each enabled cycle until CLEAR. It then holds until the next job.
- MAC_SCHED_PERF_EN undefined: no counter logic; perf_cycles_o is tied to 0.

## Structure
- Package mac_sched_pkg: state enum, and derived localparams L, T, the number of MACs, and the counter widths ($clog2-based, minimum 1 bit).
- Sub-module mac_sched_buffer: an L×width_p operand register file. It has one write port, plus combinational skewed read ports for the array_height_p rows and array_width_p columns, indexed by t.

## Test plan
- 2×2, depth 2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] loaded as stream 1,2,3,4,5,7,6,8, behavioural array model, all ready/yumi high -> data_o sequence 19,22,43,50, then one array_reset_o pulse.
- Skew check, same load, ready high: at t=0 only row0/col0 valid with values 1/5; at t=1 all valid with row0=2, row1=3, col0=7, col1=6; at t=2 only row1/col1 valid with 4/8.
- col_ready_i[1] low for 3 cycles at t=1 -> all lanes hold their t=1 values; t advances on the cycle col_ready_i[1] rises.
- yumi_i pulsed every other cycle in DRAIN -> each result is held until taken, with no skips or repeats.
- flush_i asserted mid-FEED together with valid_i -> CLEAR for one cycle with array_reset_o=1, then IDLE with ready_o=1; the next job produces correct results.
- en_i low for 5 cycles mid-LOAD, then async reset asserted during WAIT -> no progress while disabled; after reset all outputs are at reset values and the state is IDLE.

Source files
------------

// File: rtl/mac_sched_pkg.sv
// Shared types and sizing helpers for the MAC-array scheduler.
// Functions derive the sizes from a module's parameters; the localparams give the default 2x2x2 build.
package mac_sched_pkg;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_LOAD  = 6'b000010,
    S_FEED  = 6'b000100,
    S_WAIT  = 6'b001000,
    S_DRAIN = 6'b010000,
    S_CLEAR = 6'b100000
  } state_e;

  // Number of operand words in one job: A then B.
  function automatic int calc_l(input int h, input int w, input int d);
    return (h + w) * d;
  endfunction

  // Number of skewed feed steps until the last lane has delivered its last operand.
  function automatic int calc_t(input int h, input int w, input int d);
    return d + ((h > w) ? h : w) - 1;
  endfunction

  function automatic int calc_macs(input int h, input int w);
    return h * w;
  endfunction

  // Width of a counter that ranges over 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int L      = calc_l(2, 2, 2);
  localparam int T      = calc_t(2, 2, 2);
  localparam int MACS   = calc_macs(2, 2);
  localparam int L_W    = cnt_w(L);
  localparam int T_W    = cnt_w(T);
  localparam int MACS_W = cnt_w(MACS);

endpackage

// File: rtl/mac_sched_buffer.sv
// Operand register file for one job: a single write port and combinational skewed row/column reads.
// Inactive lanes read as zero, and the lane-active masks follow the systolic diagonal for step step_i.
module mac_sched_buffer
  import mac_sched_pkg::*;
#(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int depth_p        = 2
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                we_i,
  input  logic [cnt_w(calc_l(array_height_p, array_width_p, depth_p))-1:0] waddr_i,
  input  logic [width_p-1:0]                  wdata_i,
  input  logic [cnt_w(calc_t(array_height_p, array_width_p, depth_p))-1:0] step_i,
  output logic [width_p*array_height_p-1:0]   row_data_o,
  output logic [array_height_p-1:0]           row_act_o,
  output logic [width_p*array_width_p-1:0]    col_data_o,
  output logic [array_width_p-1:0]            col_act_o
);

  localparam int LN = calc_l(array_height_p, array_width_p, depth_p);
  localparam int AW = cnt_w(LN);
  localparam int B_BASE = array_height_p * depth_p;

  logic [width_p-1:0] mem_q [LN];

  // NOTE: the operand store is reset like any other state so a job started right after reset reads defined zeros.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < LN; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Row r carries A[r][step-r]; column c carries B[step-c][c], stored column-major after A.
  always_comb begin
    int            k;
    logic [AW-1:0] idx;
    // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
    k          = 0;
    idx        = '0;
    row_data_o = '0;
    row_act_o  = '0;
    col_data_o = '0;
    col_act_o  = '0;
    for (int r = 0; r < array_height_p; r++) begin
      k = int'(step_i) - r;
      if (k >= 0 && k < depth_p) begin
        idx                             = AW'(r * depth_p + k);
        row_act_o[r]                    = 1'b1;
        row_data_o[r*width_p +: width_p] = mem_q[idx];
      end
    end
    for (int c = 0; c < array_width_p; c++) begin
      k = int'(step_i) - c;
      if (k >= 0 && k < depth_p) begin
        idx                             = AW'(B_BASE + c * depth_p + k);
        col_act_o[c]                    = 1'b1;
        col_data_o[c*width_p +: width_p] = mem_q[idx];
      end
    end
  end

endmodule

// File: rtl/mac_array_scheduler.sv
// Load / skewed-feed / settle / drain sequencer in front of a mac_array instance.
// Define MAC_SCHED_PERF_EN to build the per-job cycle counter on perf_cycles_o; otherwise it is tied to zero.
module mac_array_scheduler
  import mac_sched_pkg::*;
#(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int depth_p        = 2,
  parameter int settle_p       = 4
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,
  input  logic                                              en_i,
  input  logic                                              flush_i,
  input  logic                                              valid_i,
  output logic                                              ready_o,
  input  logic [width_p-1:0]                                data_i,
  output logic [width_p*array_height_p-1:0]                 row_o,
  output logic [array_height_p-1:0]                         row_valid_o,
  input  logic [array_height_p-1:0]                         row_ready_i,
  output logic [width_p*array_width_p-1:0]                  col_o,
  output logic [array_width_p-1:0]                          col_valid_o,
  input  logic [array_width_p-1:0]                          col_ready_i,
  input  logic [width_p*array_height_p*array_width_p-1:0]   z_i,
  output logic                                              valid_o,
  input  logic                                              yumi_i,
  output logic [width_p-1:0]                                data_o,
  output logic                                              array_reset_o,
  output logic                                              busy_o,
  output logic [31:0]                                       perf_cycles_o
);

  localparam int LN = calc_l(array_height_p, array_width_p, depth_p);
  localparam int TN = calc_t(array_height_p, array_width_p, depth_p);
  localparam int MN = calc_macs(array_height_p, array_width_p);
  localparam int LW = cnt_w(LN);
  localparam int TW = cnt_w(TN);
  localparam int WW = cnt_w(settle_p);
  localparam int MW = cnt_w(MN);

  localparam logic [LW-1:0] LOAD_LAST  = LW'(LN - 1);
  localparam logic [TW-1:0] STEP_LAST  = TW'(TN - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(settle_p - 1);
  localparam logic [MW-1:0] DRAIN_LAST = MW'(MN - 1);

  state_e state_q, state_d;

  logic [LW-1:0] load_q;
  logic [TW-1:0] step_q;
  logic [WW-1:0] wait_q;
  logic [MW-1:0] drain_q;

  logic [width_p*array_height_p-1:0] row_data;
  logic [array_height_p-1:0]         row_act;
  logic [width_p*array_width_p-1:0]  col_data;
  logic [array_width_p-1:0]          col_act;

  logic flush_take, accept, feeding, feed_adv, drain_take;

  // flush wins over any same-cycle word or result handshake.
  assign flush_take = en_i & flush_i & (state_q != S_CLEAR);
  assign accept     = en_i & ~flush_i & valid_i & ((state_q == S_IDLE) | (state_q == S_LOAD));
  assign feeding    = en_i & (state_q == S_FEED);
  assign feed_adv   = feeding & ~flush_i & ~|(row_act & ~row_ready_i) & ~|(col_act & ~col_ready_i);
  assign drain_take = en_i & ~flush_i & yumi_i & (state_q == S_DRAIN);

  mac_sched_buffer #(
    .width_p        (width_p),
    .array_width_p  (array_width_p),
    .array_height_p (array_height_p),
    .depth_p        (depth_p)
  ) u_buffer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .we_i       (accept),
    .waddr_i    (load_q),
    .wdata_i    (data_i),
    .step_i     (step_q),
    .row_data_o (row_data),
    .row_act_o  (row_act),
    .col_data_o (col_data),
    .col_act_o  (col_act)
  );

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      if (flush_i && state_q != S_CLEAR) begin
        state_d = S_CLEAR;
      end else begin
        case (state_q)
          S_IDLE:  if (valid_i) state_d = S_LOAD;
          S_LOAD:  if (valid_i && load_q == LOAD_LAST) state_d = S_FEED;
          S_FEED:  if (feed_adv && step_q == STEP_LAST) state_d = S_WAIT;
          S_WAIT:  if (wait_q == WAIT_LAST) state_d = S_DRAIN;
          S_DRAIN: if (yumi_i && drain_q == DRAIN_LAST) state_d = S_CLEAR;
          S_CLEAR: state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    ready_o       = en_i & ((state_q == S_IDLE) | (state_q == S_LOAD));
    row_valid_o   = feeding ? row_act  : '0;
    row_o         = feeding ? row_data : '0;
    col_valid_o   = feeding ? col_act  : '0;
    col_o         = feeding ? col_data : '0;
    valid_o       = en_i & (state_q == S_DRAIN);
    data_o        = (state_q == S_DRAIN) ? z_i[int'(drain_q)*width_p +: width_p] : '0;
    array_reset_o = en_i & (state_q == S_CLEAR);
    busy_o        = (state_q == S_FEED) | (state_q == S_WAIT) | (state_q == S_DRAIN);
  end

  // Each counter wraps to zero on the event that leaves its state, so every state starts from zero.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      load_q  <= '0;
      step_q  <= '0;
      wait_q  <= '0;
      drain_q <= '0;
    end else if (flush_take) begin
      load_q  <= '0;
      step_q  <= '0;
      wait_q  <= '0;
      drain_q <= '0;
    end else begin
      if (accept)     load_q  <= (load_q  == LOAD_LAST)  ? '0 : load_q  + 1'b1;
      if (feed_adv)   step_q  <= (step_q  == STEP_LAST)  ? '0 : step_q  + 1'b1;
      if (en_i && state_q == S_WAIT)
                      wait_q  <= (wait_q  == WAIT_LAST)  ? '0 : wait_q  + 1'b1;
      if (drain_take) drain_q <= (drain_q == DRAIN_LAST) ? '0 : drain_q + 1'b1;
    end
  end

`ifdef MAC_SCHED_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      perf_q <= '0;
    end else if (en_i) begin
      if (accept && state_q == S_IDLE) perf_q <= '0;
      else if (state_q inside {S_LOAD, S_FEED, S_WAIT, S_DRAIN}) perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_mac_array_scheduler.sv
// Self-checking bench for mac_array_scheduler: per-feature tasks, random operands and handshakes,
// with results predicted by plain matrix arithmetic and a lane-sequence model of the MAC array.
module tb_mac_array_scheduler;

  localparam int W  = 32;
  localparam int AW = 2;
  localparam int AH = 2;
  localparam int D  = 2;
  localparam int S  = 4;
  localparam int L  = (AH + AW) * D;
  localparam int T  = D + ((AH > AW) ? AH : AW) - 1;
  localparam int M  = AH * AW;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              en_i;
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [W-1:0]      data_i;
  logic [W*AH-1:0]   row_o;
  logic [AH-1:0]     row_valid_o;
  logic [AH-1:0]     row_ready_i;
  logic [W*AW-1:0]   col_o;
  logic [AW-1:0]     col_valid_o;
  logic [AW-1:0]     col_ready_i;
  logic [W*M-1:0]    z_i;
  logic              valid_o;
  logic              yumi_i;
  logic [W-1:0]      data_o;
  logic              array_reset_o;
  logic              busy_o;
  logic [31:0]       perf_cycles_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int t0 = 0;

  logic [W-1:0] a_m [AH][D];
  logic [W-1:0] b_m [D][AW];
  logic [W-1:0] words [L];
  logic [W-1:0] exp_z [M];

  mac_array_scheduler #(
    .width_p(W), .array_width_p(AW), .array_height_p(AH), .depth_p(D), .settle_p(S)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .en_i          (en_i),
    .flush_i       (flush_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .data_i        (data_i),
    .row_o         (row_o),
    .row_valid_o   (row_valid_o),
    .row_ready_i   (row_ready_i),
    .col_o         (col_o),
    .col_valid_o   (col_valid_o),
    .col_ready_i   (col_ready_i),
    .z_i           (z_i),
    .valid_o       (valid_o),
    .yumi_i        (yumi_i),
    .data_o        (data_o),
    .array_reset_o (array_reset_o),
    .busy_o        (busy_o),
    .perf_cycles_o (perf_cycles_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Array model: records the operand sequence delivered on each lane per feed step, and
  // forms z[r][c] as the dot product of row r's and column c's sequences.
  logic [W-1:0] rseq [AH][D];
  logic [W-1:0] cseq [AW][D];
  int rn [AH];
  int cn [AW];
  logic adv_seen;

  assign adv_seen = ((|row_valid_o) || (|col_valid_o)) &&
                    ((row_valid_o & ~row_ready_i) == '0) &&
                    ((col_valid_o & ~col_ready_i) == '0);

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i || array_reset_o) begin
      for (int r = 0; r < AH; r++) rn[r] <= 0;
      for (int c = 0; c < AW; c++) cn[c] <= 0;
    end else if (adv_seen) begin
      for (int r = 0; r < AH; r++)
        if (row_valid_o[r] && rn[r] < D) begin
          rseq[r][rn[r]] <= row_o[r*W +: W];
          rn[r] <= rn[r] + 1;
        end
      for (int c = 0; c < AW; c++)
        if (col_valid_o[c] && cn[c] < D) begin
          cseq[c][cn[c]] <= col_o[c*W +: W];
          cn[c] <= cn[c] + 1;
        end
    end
  end

  always_comb begin
    logic [W-1:0] acc;
    acc = '0;
    z_i = '0;
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++) begin
        acc = '0;
        for (int k = 0; k < D; k++)
          if (k < rn[r] && k < cn[c]) acc = acc + rseq[r][k] * cseq[c][k];
        z_i[(r*AW + c)*W +: W] = acc;
      end
  end

  task automatic build_job(input bit fixed);
    int n;
    logic [W-1:0] s;
    for (int r = 0; r < AH; r++)
      for (int k = 0; k < D; k++)
        a_m[r][k] = fixed ? W'(r*D + k + 1) : $urandom;
    for (int k = 0; k < D; k++)
      for (int c = 0; c < AW; c++)
        b_m[k][c] = fixed ? W'(AH*D + k*AW + c + 1) : $urandom;
    n = 0;
    for (int r = 0; r < AH; r++)
      for (int k = 0; k < D; k++) begin words[n] = a_m[r][k]; n++; end
    for (int c = 0; c < AW; c++)
      for (int k = 0; k < D; k++) begin words[n] = b_m[k][c]; n++; end
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++) begin
        s = '0;
        for (int k = 0; k < D; k++) s = s + a_m[r][k] * b_m[k][c];
        exp_z[r*AW + c] = s;
      end
  endtask

  task automatic do_load(input int first, input int last, input bit gaps);
    int k, guard;
    bit go;
    k = first;
    guard = 0;
    while (k <= last && guard < 200) begin
      @(negedge clk_i);
      guard++;
      total_cnt++;
      if (ready_o !== 1'b1) $display("FAIL load_ready: got %b expected 1", ready_o);
      else pass_cnt++;
      valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      data_i  = valid_i ? words[k] : $urandom;
      go = valid_i && ready_o;
      @(posedge clk_i);
      #1;
      if (go) begin
        if (k == 0) t0 = cyc;
        k++;
      end
    end
    valid_i = 1'b0;
    total_cnt++;
    if (k <= last) $display("FAIL load_timeout: got %0d words expected %0d", k, last + 1);
    else pass_cnt++;
  endtask

  // mode 0: all ready; 1: random readies; 2: col_ready_i[1] low for 3 cycles at t=1.
  task automatic do_feed(input int mode);
    int t, stall, guard;
    bit ev, adv;
    logic [W-1:0] ed;
    t = 0; stall = 0; guard = 0;
    while (t < T && guard < 300) begin
      @(negedge clk_i);
      guard++;
      total_cnt++;
      if (busy_o !== 1'b1) $display("FAIL feed_busy: got %b expected 1 at t=%0d", busy_o, t);
      else pass_cnt++;
      for (int r = 0; r < AH; r++) begin
        ev = (t >= r) && (t < r + D);
        ed = ev ? a_m[r][t - r] : '0;
        total_cnt++;
        if (row_valid_o[r] !== ev || row_o[r*W +: W] !== ed)
          $display("FAIL feed_row%0d t=%0d: got v=%b d=%0d expected v=%b d=%0d",
                   r, t, row_valid_o[r], row_o[r*W +: W], ev, ed);
        else pass_cnt++;
      end
      for (int c = 0; c < AW; c++) begin
        ev = (t >= c) && (t < c + D);
        ed = ev ? b_m[t - c][c] : '0;
        total_cnt++;
        if (col_valid_o[c] !== ev || col_o[c*W +: W] !== ed)
          $display("FAIL feed_col%0d t=%0d: got v=%b d=%0d expected v=%b d=%0d",
                   c, t, col_valid_o[c], col_o[c*W +: W], ev, ed);
        else pass_cnt++;
      end
      row_ready_i = '1;
      col_ready_i = '1;
      if (mode == 1) begin
        for (int r = 0; r < AH; r++) row_ready_i[r] = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < AW; c++) col_ready_i[c] = ($urandom_range(0, 3) != 0);
      end else if (mode == 2 && t == 1 && stall < 3) begin
        col_ready_i[1] = 1'b0;
        stall++;
      end
      adv = 1'b1;
      for (int r = 0; r < AH; r++) if (t >= r && t < r + D && !row_ready_i[r]) adv = 1'b0;
      for (int c = 0; c < AW; c++) if (t >= c && t < c + D && !col_ready_i[c]) adv = 1'b0;
      if (adv) t++;
    end
    total_cnt++;
    if (t < T) $display("FAIL feed_timeout: got step %0d expected %0d", t, T);
    else pass_cnt++;
  endtask

  task automatic do_wait();
    int n;
    row_ready_i = '1;
    col_ready_i = '1;
    n = 0;
    @(negedge clk_i);
    while (!valid_o && n < 50) begin
      n++;
      @(negedge clk_i);
    end
    total_cnt++;
    if (n != S) $display("FAIL wait_cycles: got %0d expected %0d", n, S);
    else pass_cnt++;
  endtask

  // Starts at the first DRAIN negedge. mode 0: yumi always; 1: every other cycle; 2: random.
  task automatic do_drain(input int mode);
    int i, guard;
    bit y;
    i = 0; guard = 0;
    while (i < M && guard < 200) begin
      total_cnt++;
      if (valid_o !== 1'b1 || data_o !== exp_z[i])
        $display("FAIL drain_result%0d: got v=%b d=%0d expected v=1 d=%0d", i, valid_o, data_o, exp_z[i]);
      else pass_cnt++;
      case (mode)
        1:       y = (guard % 2) == 1;
        2:       y = ($urandom_range(0, 2) != 0);
        default: y = 1'b1;
      endcase
      yumi_i = y;
      if (y) i++;
      guard++;
      @(negedge clk_i);
    end
    yumi_i = 1'b0;
    total_cnt++;
    if (i < M) $display("FAIL drain_timeout: got %0d results expected %0d", i, M);
    else pass_cnt++;
  endtask

  task automatic do_clear(input bit check_latency);
    total_cnt++;
    if (array_reset_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0 || ready_o !== 1'b0)
      $display("FAIL clear_pulse: got rst=%b v=%b busy=%b rdy=%b expected 1 0 0 0",
               array_reset_o, valid_o, busy_o, ready_o);
    else pass_cnt++;
    @(negedge clk_i);
    total_cnt++;
    if (array_reset_o !== 1'b0 || ready_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL clear_to_idle: got rst=%b rdy=%b busy=%b expected 0 1 0",
               array_reset_o, ready_o, busy_o);
    else pass_cnt++;
    if (check_latency) begin
      total_cnt++;
      if (cyc - t0 + 1 != L + T + S + M + 1)
        $display("FAIL job_latency: got %0d expected %0d", cyc - t0 + 1, L + T + S + M + 1);
      else pass_cnt++;
      total_cnt++;
`ifdef MAC_SCHED_PERF_EN
      if (perf_cycles_o !== 32'(L - 1 + T + S + M))
        $display("FAIL perf_cycles: got %0d expected %0d", perf_cycles_o, L - 1 + T + S + M);
      else pass_cnt++;
`else
      if (perf_cycles_o !== 32'd0) $display("FAIL perf_cycles: got %0d expected 0", perf_cycles_o);
      else pass_cnt++;
`endif
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    total_cnt++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || row_valid_o !== '0 || col_valid_o !== '0 ||
        array_reset_o !== 1'b0 || busy_o !== 1'b0 || perf_cycles_o !== 32'd0)
      $display("FAIL %s: got rdy=%b v=%b rv=%b cv=%b arst=%b busy=%b perf=%0d expected 1 0 0 0 0 0 0",
               tag, ready_o, valid_o, row_valid_o, col_valid_o, array_reset_o, busy_o, perf_cycles_o);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; en_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; data_i = '0;
    row_ready_i = '1; col_ready_i = '1; yumi_i = 1'b0;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check_idle_outputs("reset_state");
  endtask

  task automatic test_basic();
    build_job(1'b1);
    do_load(0, L - 1, 1'b0);
    do_feed(0);
    do_wait();
    do_drain(0);
    do_clear(1'b1);
  endtask

  task automatic test_stall_and_yumi();
    build_job(1'b1);
    do_load(0, L - 1, 1'b0);
    do_feed(2);
    do_wait();
    do_drain(1);
    do_clear(1'b0);
  endtask

  task automatic test_flush();
    build_job(1'b0);
    do_load(0, L - 1, 1'b0);
    row_ready_i = '1;
    col_ready_i = '1;
    @(negedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b1;
    valid_i = 1'b1;
    data_i  = $urandom;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk_i);
    total_cnt++;
    if (array_reset_o !== 1'b1 || busy_o !== 1'b0 || row_valid_o !== '0 || ready_o !== 1'b0)
      $display("FAIL flush_clear: got arst=%b busy=%b rv=%b rdy=%b expected 1 0 0 0",
               array_reset_o, busy_o, row_valid_o, ready_o);
    else pass_cnt++;
    @(negedge clk_i);
    total_cnt++;
    if (array_reset_o !== 1'b0 || ready_o !== 1'b1)
      $display("FAIL flush_idle: got arst=%b rdy=%b expected 0 1", array_reset_o, ready_o);
    else pass_cnt++;
    build_job(1'b0);
    do_load(0, L - 1, 1'b0);
    do_feed(0);
    do_wait();
    do_drain(0);
    do_clear(1'b0);
  endtask

  task automatic test_enable_and_reset();
    build_job(1'b0);
    do_load(0, 2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      en_i    = 1'b0;
      valid_i = 1'b1;
      data_i  = $urandom;
      #1;
      total_cnt++;
      if (ready_o !== 1'b0 || busy_o !== 1'b0 || array_reset_o !== 1'b0)
        $display("FAIL disabled_outputs: got rdy=%b busy=%b arst=%b expected 0 0 0",
                 ready_o, busy_o, array_reset_o);
      else pass_cnt++;
    end
    @(negedge clk_i);
    en_i    = 1'b1;
    valid_i = 1'b0;
    do_load(3, L - 1, 1'b0);
    do_feed(1);
    row_ready_i = '1;
    col_ready_i = '1;
    repeat (2) @(negedge clk_i);
    total_cnt++;
    if (busy_o !== 1'b1 || valid_o !== 1'b0)
      $display("FAIL in_wait: got busy=%b v=%b expected 1 0", busy_o, valid_o);
    else pass_cnt++;
    #1 reset_i = 1'b1;
    #1;
    total_cnt++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || array_reset_o !== 1'b0)
      $display("FAIL async_reset: got busy=%b v=%b arst=%b expected 0 0 0", busy_o, valid_o, array_reset_o);
    else pass_cnt++;
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check_idle_outputs("post_reset_state");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      total_cnt++;
      if (valid_o !== 1'b0 || array_reset_o !== 1'b0 || busy_o !== 1'b0)
        $display("FAIL post_reset_quiet: got v=%b arst=%b busy=%b expected 0 0 0", valid_o, array_reset_o, busy_o);
      else pass_cnt++;
    end
  endtask

  task automatic test_random_back_to_back();
    for (int j = 0; j < 4; j++) begin
      build_job(1'b0);
      do_load(0, L - 1, 1'b1);
      do_feed(1);
      do_wait();
      do_drain(2);
      do_clear(1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_and_yumi();
    test_flush();
    test_enable_and_reset();
    test_random_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
